ldst_sequencer: RTL and testbench

Multi-cycle control sequencer for the load/store datapath: fetches one instruction and steps through T-states to execute `ld`, `ldi` and `st` over the shared bus. It produces the register select/enable strobes, including `ba_out`, which forces R0 to drive zero for base-address calculation. It sits beside the register file, ALU Y/Z registers, MAR/MDR and PC, replacing hand-driven testbench control.

---
 rtl/cpu_ctrl_pkg.sv | 24 ++
 rtl/mem_wait_timer.sv | 18 +
 rtl/ldst_sequencer.sv | 104 ++++++++++
 tb/tb_ldst_sequencer.sv | 108 ++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared opcodes, sequencer states, IR field positions and bus-driver encoding.
package cpu_ctrl_pkg;
  localparam logic [4:0] OPC_LD  = 5'b00000;
  localparam logic [4:0] OPC_LDI = 5'b00001;
  localparam logic [4:0] OPC_ST  = 5'b00010;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int C_MSB = 18;
  localparam int C_LSB = 0;
  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_DONE, S_ERR
  } state_t;
  typedef enum logic [4:0] {
    BUS_NONE = 5'b00000,
    BUS_PC   = 5'b10000,
    BUS_MDR  = 5'b01000,
    BUS_ZLO  = 5'b00100,
    BUS_C    = 5'b00010,
    BUS_R    = 5'b00001
  } bus_drv_t;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts stalled cycles in a memory wait state, flags the last allowed one.
module mem_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic clr,
  input  logic wait_i,
  input  logic stall_i,
  output logic expired_o
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = !wait_i ? '0 : stall_i ? cnt_q + 1'b1 : cnt_q;
  assign expired_o = stall_i && (cnt_q == CW'(LIMIT - 1));
  always_ff @(posedge clk or negedge clr)
    if (!clr) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/ldst_sequencer.sv
// ldst_sequencer: T-state control sequencer executing ld/ldi/st over the shared bus.
// Define LDST_MEM_TIMEOUT_EN to send memory waits longer than TIMEOUT_CYCLES to ERR.
module ldst_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPC_W = 5,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        pc_out,
  output logic        mdr_out,
  output logic        zlo_out,
  output logic        c_out,
  output logic        rout,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        rin,
  output logic        pc_inc,
  output logic        gra,
  output logic        grb,
  output logic        ba_out,
  output logic        read,
  output logic        write,
  output logic        alu_add,
  output logic        busy,
  output logic        done,
  output logic        illegal
);
  state_t state_q, state_d;
  bus_drv_t bus;
  logic [OPC_W-1:0] opc_q, opc_d, opc_ir;
  logic is_ld, is_ldi, is_st, legal, wt, stall, expired;
  logic unused_ir;
  assign opc_ir = ir[OPC_LSB +: OPC_W];
  assign unused_ir = ^{ir[RA_MSB:RA_LSB], ir[RB_MSB:RB_LSB], ir[C_MSB:C_LSB]};
  assign legal = opc_ir == OPC_W'(OPC_LD) || opc_ir == OPC_W'(OPC_LDI) || opc_ir == OPC_W'(OPC_ST);
  assign opc_d = (state_q == S_T3) ? opc_ir : opc_q;
  assign is_ld = opc_q == OPC_W'(OPC_LD);
  assign is_ldi = opc_q == OPC_W'(OPC_LDI);
  assign is_st = opc_q == OPC_W'(OPC_ST);
  assign wt = state_q == S_T1 || (state_q == S_T6 && is_ld) || (state_q == S_T7 && is_st);
  assign stall = wt && !mem_ready;
`ifdef LDST_MEM_TIMEOUT_EN
  mem_wait_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wait (
    .clk(clk), .clr(clr), .wait_i(wt), .stall_i(stall), .expired_o(expired)
  );
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state_q <= S_IDLE;
      opc_q <= '0;
    end else begin
      state_q <= state_d;
      opc_q <= opc_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = start ? S_T0 : S_IDLE;
      S_T0: state_d = S_T1;
      S_T1: state_d = mem_ready ? S_T2 : S_T1;
      S_T2: state_d = S_T3;
      S_T3: state_d = legal ? S_T4 : S_ERR;
      S_T4: state_d = S_T5;
      S_T5: state_d = is_ldi ? S_DONE : S_T6;
      S_T6: state_d = (!is_ld || mem_ready) ? S_T7 : S_T6;
      S_T7: state_d = (is_ld || mem_ready) ? S_DONE : S_T7;
      default: state_d = S_ERR;
    endcase
    if (stall && expired) state_d = S_ERR;
  end
  // Moore decode: every strobe is a function of the registered state and latched opcode only.
  always_comb begin
    bus = BUS_NONE;
    {mar_in, mdr_in, ir_in, y_in, z_in, rin, pc_inc} = '0;
    {gra, grb, ba_out, read, write, alu_add, done, illegal} = '0;
    busy = state_q != S_IDLE;
    case (state_q)
      S_T0: begin bus = BUS_PC; mar_in = 1'b1; pc_inc = 1'b1; end
      S_T1: begin read = 1'b1; mdr_in = 1'b1; end
      S_T2: begin bus = BUS_MDR; ir_in = 1'b1; end
      S_T3: begin bus = BUS_R; grb = 1'b1; ba_out = 1'b1; y_in = 1'b1; end
      S_T4: begin bus = BUS_C; alu_add = 1'b1; z_in = 1'b1; end
      S_T5: begin bus = BUS_ZLO; gra = is_ldi; rin = is_ldi; mar_in = !is_ldi; end
      S_T6: begin bus = is_ld ? BUS_NONE : BUS_R; read = is_ld; gra = !is_ld; mdr_in = 1'b1; end
      S_T7: begin bus = is_ld ? BUS_MDR : BUS_NONE; gra = is_ld; rin = is_ld; write = !is_ld; end
      S_DONE: done = 1'b1;
      S_ERR: illegal = 1'b1;
      default: ;
    endcase
  end
  assign {pc_out, mdr_out, zlo_out, c_out, rout} = bus;
endmodule

// File: tb/tb_ldst_sequencer.sv
// tb_ldst_sequencer: directed instruction runs checked cycle by cycle against hand-built strobe vectors.
module tb_ldst_sequencer;
  logic clk = 1'b0, clr = 1'b0, start = 1'b0, mem_ready = 1'b0;
  logic [31:0] ir = '0;
  logic pc_out, mdr_out, zlo_out, c_out, rout, mar_in, mdr_in, ir_in, y_in, z_in, rin, pc_inc;
  logic gra, grb, ba_out, read, write, alu_add, busy, done, illegal;
  int n_vec = 0, n_bad = 0;
  logic [20:0] ex[$];
  always #5 clk = ~clk;
  ldst_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .mem_ready(mem_ready),
    .pc_out(pc_out), .mdr_out(mdr_out), .zlo_out(zlo_out), .c_out(c_out), .rout(rout),
    .mar_in(mar_in), .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .rin(rin),
    .pc_inc(pc_inc), .gra(gra), .grb(grb), .ba_out(ba_out), .read(read), .write(write),
    .alu_add(alu_add), .busy(busy), .done(done), .illegal(illegal)
  );
  logic [20:0] outs;
  assign outs = {pc_out, mdr_out, zlo_out, c_out, rout, mar_in, mdr_in, ir_in, y_in, z_in, rin,
                 pc_inc, gra, grb, ba_out, read, write, alu_add, busy, done, illegal};
  localparam logic [20:0] PC = 21'h1 << 20, MDRO = 21'h1 << 19, ZLO = 21'h1 << 18, CO = 21'h1 << 17;
  localparam logic [20:0] RO = 21'h1 << 16, MARI = 21'h1 << 15, MDRI = 21'h1 << 14, IRI = 21'h1 << 13;
  localparam logic [20:0] YI = 21'h1 << 12, ZI = 21'h1 << 11, RIN = 21'h1 << 10, PCI = 21'h1 << 9;
  localparam logic [20:0] GRA = 21'h1 << 8, GRB = 21'h1 << 7, BA = 21'h1 << 6, RD = 21'h1 << 5;
  localparam logic [20:0] WR = 21'h1 << 4, ADD = 21'h1 << 3, BSY = 21'h1 << 2, DN = 21'h1 << 1, ILL = 21'h1;
  localparam logic [20:0] V_T0 = PC | MARI | PCI | BSY, V_T1 = RD | MDRI | BSY, V_T2 = MDRO | IRI | BSY;
  localparam logic [20:0] V_T3 = GRB | BA | RO | YI | BSY, V_T4 = CO | ADD | ZI | BSY;
  localparam logic [20:0] V_T5I = ZLO | GRA | RIN | BSY, V_T5M = ZLO | MARI | BSY;
  localparam logic [20:0] V_T6L = RD | MDRI | BSY, V_T6S = GRA | RO | MDRI | BSY;
  localparam logic [20:0] V_T7L = MDRO | GRA | RIN | BSY, V_T7S = WR | BSY;
  localparam logic [20:0] V_DN = DN | BSY, V_ERR = ILL | BSY, V_IDLE = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [3:0] ra, input logic [3:0] rb,
                                     input logic [18:0] c);
    return {opc, ra, rb, c};
  endfunction
  task automatic run(input string tag, input logic [31:0] ir_v, input int ws, input int wl, input bit hold);
    ir = ir_v;
    start = 1'b1;
    for (int i = 0; i < ex.size(); i++) begin
      @(negedge clk);
      check($sformatf("%s c%0d", tag, i + 1), {11'b0, outs}, {11'b0, ex[i]});
      check($sformatf("%s c%0d excl", tag, i + 1),
            {30'b0, $countones({pc_out, mdr_out, zlo_out, c_out, rout}) <= 1, !(read && write)}, 32'h3);
      start = hold;
      mem_ready = !(i >= ws && i < ws + wl);
    end
  endtask
  initial begin
    #3 check("reset outs", {11'b0, outs}, 32'h0);
    @(negedge clk) clr = 1'b1;
    @(negedge clk) check("idle", {11'b0, outs}, 32'h0);
    ex = '{V_T0, V_T1, V_T2, V_T3, V_T4, V_T5I, V_DN};
    run("ldi", mk(5'b00001, 4'd2, 4'd0, 19'd10), 99, 0, 1'b0);
    @(negedge clk) check("ldi->idle", {11'b0, outs}, {11'b0, V_IDLE});
    ex = '{V_T0, V_T1, V_T2, V_T3, V_T4, V_T5M, V_T6L, V_T7L, V_DN};
    run("ld", mk(5'b00000, 4'd1, 4'd3, 19'd4), 99, 0, 1'b0);
    ex = '{V_T0, V_T1, V_T2, V_T3, V_T4, V_T5M, V_T6S, V_T7S, V_T7S, V_T7S, V_T7S, V_DN};
    run("st", mk(5'b00010, 4'd5, 4'd6, 19'd7), 7, 3, 1'b0);
    ex = '{V_T0, V_T1, V_T1, V_T1, V_T2, V_T3, V_T4, V_T5M, V_T6L, V_T7L, V_DN};
    run("ld t1wait", mk(5'b00000, 4'd4, 4'd0, 19'h7ffff), 1, 2, 1'b0);
    ex = '{V_T0, V_T1, V_T2, V_T3, V_T4, V_T5I, V_DN};
    run("b2b a", mk(5'b00001, 4'd7, 4'd1, 19'd1), 99, 0, 1'b1);
    run("b2b b", mk(5'b00001, 4'd8, 4'd2, 19'd2), 99, 0, 1'b0);
    ex = '{V_T0, V_T1, V_T2, V_T3, V_ERR};
    run("illegal", mk(5'b11111, 4'd1, 4'd1, 19'd0), 99, 0, 1'b0);
    start = 1'b1;
    repeat (3) @(negedge clk) check("err sticky", {11'b0, outs}, {11'b0, V_ERR});
    start = 1'b0;
    clr = 1'b0;
    #1 check("err reset", {11'b0, outs}, 32'h0);
    @(negedge clk) clr = 1'b1;
    ex = '{V_T0, V_T1, V_T2, V_T3, V_T4, V_T5M, V_T6L};
    run("ld abort", mk(5'b00000, 4'd2, 4'd3, 19'd4), 6, 1, 1'b0);
    #2 clr = 1'b0;
    #1 check("async clr", {11'b0, outs}, 32'h0);
    @(negedge clk) check("clr held", {11'b0, outs}, 32'h0);
    clr = 1'b1;
    ex = '{V_T0, V_T1, V_T2, V_T3, V_T4, V_T5I, V_DN};
    run("after clr", mk(5'b00001, 4'd3, 4'd0, 19'd5), 99, 0, 1'b0);
`ifdef LDST_MEM_TIMEOUT_EN
    ex = '{V_T0};
    repeat (15) ex.push_back(V_T1);
    ex.push_back(V_ERR);
    run("timeout", mk(5'b00000, 4'd1, 4'd2, 19'd3), 1, 100, 1'b0);
    @(negedge clk) check("timeout sticky", {11'b0, outs}, {11'b0, V_ERR});
`else
    ex = '{V_T0};
    repeat (21) ex.push_back(V_T1);
    ex.push_back(V_T2);
    ex.push_back(V_T3);
    ex.push_back(V_T4);
    ex.push_back(V_T5M);
    ex.push_back(V_T6L);
    ex.push_back(V_T7L);
    ex.push_back(V_DN);
    run("long wait", mk(5'b00000, 4'd1, 4'd2, 19'd3), 1, 20, 1'b0);
    @(negedge clk) check("long wait idle", {11'b0, outs}, {11'b0, V_IDLE});
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
